// File: rtl/fpu_mult_pkg.sv
// fpu_mult_pkg: shared types and constants for the sequential binary32 multiplier.
package fpu_mult_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        MULT   = 3'd2,
        NORM   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int EXP_BIAS  = 127;
    localparam int EXP_MAX   = 255;
    localparam int FRAC_W    = 23;
    localparam int MANT_W    = 24;
    localparam int EXT_EXP_W = 10;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    // Mantissa with the hidden one restored (operands with exp==0 never reach the multiplier).
    function automatic logic [MANT_W-1:0] mant_of(input logic [31:0] f);
        return {1'b1, f[FRAC_W-1:0]};
    endfunction

endpackage

// File: rtl/fpu_mult_seq_if.sv
// fpu_mult_seq_if: operand-issue / result-writeback handshake bundle of the multiplier.
interface fpu_mult_seq_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflag;
    logic        underflag;

    modport master (
        output in_valid, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, overflag, underflag
    );

    modport slave (
        input  in_valid, op_a, op_b, out_ready,
        output in_ready, out_valid, result, overflag, underflag
    );

endinterface

// File: rtl/mant_mul_iter.sv
// mant_mul_iter: iterative shift-add 24x24 mantissa multiplier, BITS_PER_CYCLE bits per step.
module mant_mul_iter #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [23:0] mcand,
    input  logic [23:0] mplier,
    output logic [47:0] product
);

    logic [47:0] acc_q;
    logic [47:0] mcand_q;
    logic [23:0] mplier_q;
    logic [47:0] partial;

    // Sum of the multiplicand copies selected by the low multiplier bits this step.
    always_comb begin
        partial = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (mplier_q[j]) partial = partial + (mcand_q << j);
        end
    end

    // Accumulate, then move the multiplicand up and the multiplier down by one step width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (load) begin
            acc_q    <= '0;
            mcand_q  <= {24'b0, mcand};
            mplier_q <= mplier;
        end else if (step) begin
            acc_q    <= acc_q + partial;
            mcand_q  <= mcand_q << BITS_PER_CYCLE;
            mplier_q <= mplier_q >> BITS_PER_CYCLE;
        end
    end

    assign product = acc_q;

endmodule

// File: rtl/fpu_mult_seq.sv
// fpu_mult_seq: multi-cycle binary32 multiplier (unpack, shift-add, normalize, pack).
// Optional NaN/Inf handling is compiled in when FPU_MULT_SPECIAL_EN is defined.
module fpu_mult_seq #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    fpu_mult_seq_if.slave bus
);
    import fpu_mult_pkg::*;

    localparam logic [4:0] MULT_CYCLES = 5'(MANT_W / BITS_PER_CYCLE);

    state_t                        state_q, state_d;
    logic [31:0]                   opa_q, opb_q;
    logic                          sign_q;
    logic signed [EXT_EXP_W-1:0]   exp_q;
    logic [4:0]                    cnt_q;
    logic [31:0]                   result_q;
    logic                          over_q, under_q, out_valid_q;
    logic                          accept, mul_load, mul_step;
    logic [47:0]                   product;

    logic [7:0]                    ea, eb;
    logic                          sign_u, fast_u;
    logic signed [EXT_EXP_W-1:0]   exp_u;
    logic [31:0]                   fast_res;

    // Pick the fraction window from the product MSB, then clamp the exponent range.
    // Returns {overflag, underflag, result}.
    function automatic logic [33:0] norm_pack(input logic sgn,
                                              input logic signed [EXT_EXP_W-1:0] e,
                                              input logic [47:0] p);
        logic signed [EXT_EXP_W-1:0] en;
        logic [FRAC_W-1:0]           fr;
        logic [33:0]                 r;
        if (p[47]) begin
            fr = p[46:24];
            en = e + 10'sd1;
        end else begin
            fr = p[45:23];
            en = e;
        end
        if (en >= signed'(10'(EXP_MAX)))  r = {2'b10, sgn, 8'hFF, 23'h0};
        else if (en <= 10'sd0)             r = {2'b01, sgn, 31'h0};
        else                               r = {2'b00, sgn, en[7:0], fr};
        return r;
    endfunction

    assign ea = opa_q[30:23];
    assign eb = opb_q[30:23];

`ifdef FPU_MULT_SPECIAL_EN
    logic a_spec, b_spec, a_nan, b_nan, a_zero, b_zero;
    assign a_spec = (ea == 8'(EXP_MAX));
    assign b_spec = (eb == 8'(EXP_MAX));
    assign a_nan  = a_spec && (opa_q[FRAC_W-1:0] != '0);
    assign b_nan  = b_spec && (opb_q[FRAC_W-1:0] != '0);
    assign a_zero = (ea == 8'd0);
    assign b_zero = (eb == 8'd0);
`endif

    // Operand classification and exponent sum for the UNPACK cycle.
    always_comb begin
        sign_u   = opa_q[31] ^ opb_q[31];
        exp_u    = signed'({2'b00, ea}) + signed'({2'b00, eb}) - signed'(10'(EXP_BIAS));
        fast_u   = (ea == 8'd0) || (eb == 8'd0);
        fast_res = {sign_u, 31'h0};
`ifdef FPU_MULT_SPECIAL_EN
        if (a_nan || b_nan || (a_spec && b_zero) || (b_spec && a_zero)) begin
            fast_u   = 1'b1;
            fast_res = QNAN;
        end else if (a_spec || b_spec) begin
            fast_u   = 1'b1;
            fast_res = {sign_u, 8'hFF, 23'h0};
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = UNPACK;
            UNPACK:  state_d = fast_u ? DONE : MULT;
            MULT:    if (cnt_q == 5'd1) state_d = NORM;
            NORM:    state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM control outputs.
    always_comb begin
        bus.in_ready = (state_q == IDLE);
        accept       = bus.in_valid && (state_q == IDLE);
        mul_load     = (state_q == UNPACK) && !fast_u;
        mul_step     = (state_q == MULT);
    end

    // Operand latch, exponent/sign, iteration counter and packed result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q       <= '0;
            opb_q       <= '0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            over_q      <= 1'b0;
            under_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= (state_d == DONE);
            if (accept) begin
                opa_q <= bus.op_a;
                opb_q <= bus.op_b;
            end
            if (state_q == UNPACK) begin
                sign_q <= sign_u;
                exp_q  <= exp_u;
                cnt_q  <= MULT_CYCLES;
                if (fast_u) begin
                    result_q <= fast_res;
                    over_q   <= 1'b0;
                    under_q  <= 1'b0;
                end
            end
            if (state_q == MULT) cnt_q <= cnt_q - 5'd1;
            if (state_q == NORM) {over_q, under_q, result_q} <= norm_pack(sign_q, exp_q, product);
        end
    end

    mant_mul_iter #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_mant_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (mul_load),
        .step    (mul_step),
        .mcand   (mant_of(opa_q)),
        .mplier  (mant_of(opb_q)),
        .product (product)
    );

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.overflag  = over_q;
    assign bus.underflag = under_q;

endmodule

// File: tb/tb_fpu_mult_seq.sv
// tb_fpu_mult_seq: directed-vector bench for fpu_mult_seq.
module tb_fpu_mult_seq;

    localparam int BPC = 1;
    localparam int LAT = 3 + 24 / BPC;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        ov;
        logic        un;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    fpu_mult_seq_if bus();

    fpu_mult_seq #(.BITS_PER_CYCLE(BPC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Issue one operation from IDLE and wait (bounded) for out_valid; lat=-1 on timeout.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic ov, output logic un,
                         output int lat);
        bus.op_a = a;
        bus.op_b = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            if (bus.out_valid) begin
                lat = n;
                break;
            end
            @(posedge clk); #1;
        end
        res = bus.result;
        ov  = bus.overflag;
        un  = bus.underflag;
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({bus.in_ready, bus.out_valid, bus.overflag, bus.underflag} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 1000", {bus.in_ready, bus.out_valid, bus.overflag, bus.underflag});
        end
        vectors++;
        if (bus.result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_result: got %h expected 00000000", bus.result);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        vec_t tbl[$];
        logic [31:0] res; logic ov, un; int lat;
        tbl.push_back('{32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0, LAT});
        tbl.push_back('{32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 1'b0, LAT});
        tbl.push_back('{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, LAT});
        tbl.push_back('{32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0, LAT});
        tbl.push_back('{32'h40400000, 32'h40400000, 32'h41100000, 1'b0, 1'b0, LAT});
        foreach (tbl[i]) begin
            do_op(tbl[i].a, tbl[i].b, res, ov, un, lat);
            vectors++;
            if (lat !== tbl[i].lat) begin
                miscompares++;
                $display("FAIL arith_lat[%0d]: got %0d expected %0d", i, lat, tbl[i].lat);
            end
            vectors++;
            if ({ov, un, res} !== {tbl[i].ov, tbl[i].un, tbl[i].r}) begin
                miscompares++;
                $display("FAIL arith_res[%0d]: got %b%b_%h expected %b%b_%h", i, ov, un, res, tbl[i].ov, tbl[i].un, tbl[i].r);
            end
            handshake();
            vectors++;
            if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
                miscompares++;
                $display("FAIL arith_release[%0d]: got out_valid/in_ready %b expected 01", i, {bus.out_valid, bus.in_ready});
            end
        end
    endtask

    task automatic test_range();
        vec_t tbl[$];
        logic [31:0] res; logic ov, un; int lat;
        tbl.push_back('{32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0, LAT});
        tbl.push_back('{32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0, LAT});
        tbl.push_back('{32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0, 1'b0, LAT});
        tbl.push_back('{32'hFF400000, 32'h3FC00000, 32'hFF800000, 1'b1, 1'b0, LAT});
        tbl.push_back('{32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1, LAT});
        tbl.push_back('{32'h00800000, 32'h3F000000, 32'h00000000, 1'b0, 1'b1, LAT});
        tbl.push_back('{32'h00800000, 32'h3F800000, 32'h00800000, 1'b0, 1'b0, LAT});
        foreach (tbl[i]) begin
            do_op(tbl[i].a, tbl[i].b, res, ov, un, lat);
            vectors++;
            if (lat !== tbl[i].lat) begin
                miscompares++;
                $display("FAIL range_lat[%0d]: got %0d expected %0d", i, lat, tbl[i].lat);
            end
            vectors++;
            if ({ov, un, res} !== {tbl[i].ov, tbl[i].un, tbl[i].r}) begin
                miscompares++;
                $display("FAIL range_res[%0d]: got %b%b_%h expected %b%b_%h", i, ov, un, res, tbl[i].ov, tbl[i].un, tbl[i].r);
            end
            handshake();
        end
    endtask

    task automatic test_zero_path();
        vec_t tbl[$];
        logic [31:0] res; logic ov, un; int lat;
        tbl.push_back('{32'h00000000, 32'hC0000000, 32'h80000000, 1'b0, 1'b0, 2});
        tbl.push_back('{32'h00000001, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 2});
        tbl.push_back('{32'h40000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 2});
`ifdef FPU_MULT_SPECIAL_EN
        tbl.push_back('{32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0, 2});
        tbl.push_back('{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0, 2});
        tbl.push_back('{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0, 2});
        tbl.push_back('{32'hFF800000, 32'hFF800000, 32'h7F800000, 1'b0, 1'b0, 2});
`else
        tbl.push_back('{32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1, 1'b0, LAT});
        tbl.push_back('{32'h7F800000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 2});
`endif
        foreach (tbl[i]) begin
            do_op(tbl[i].a, tbl[i].b, res, ov, un, lat);
            vectors++;
            if (lat !== tbl[i].lat) begin
                miscompares++;
                $display("FAIL fast_lat[%0d]: got %0d expected %0d", i, lat, tbl[i].lat);
            end
            vectors++;
            if ({ov, un, res} !== {tbl[i].ov, tbl[i].un, tbl[i].r}) begin
                miscompares++;
                $display("FAIL fast_res[%0d]: got %b%b_%h expected %b%b_%h", i, ov, un, res, tbl[i].ov, tbl[i].un, tbl[i].r);
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res; logic ov, un; int lat;
        int spurious;
        do_op(32'h40000000, 32'h40400000, res, ov, un, lat);
        vectors++;
        if (res !== 32'h40C00000) begin
            miscompares++;
            $display("FAIL bp_first: got %h expected 40C00000", res);
        end
        for (int c = 0; c < 10; c++) begin
            bus.op_a = 32'h3FC00000;
            bus.op_b = 32'h3FC00000;
            bus.in_valid = 1'b1;
            vectors++;
            if ({bus.out_valid, bus.in_ready, bus.overflag, bus.underflag, bus.result} !== {4'b1000, 32'h40C00000}) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got vld/rdy/ov/un %b result %h expected 1000 40C00000", c,
                         {bus.out_valid, bus.in_ready, bus.overflag, bus.underflag}, bus.result);
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        handshake();
        vectors++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL bp_release: got out_valid/in_ready %b expected 01", {bus.out_valid, bus.in_ready});
        end
        spurious = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.out_valid) spurious++;
            @(posedge clk); #1;
        end
        vectors++;
        if (spurious != 0) begin
            miscompares++;
            $display("FAIL bp_second_accepted: got %0d out_valid cycles expected 0", spurious);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] res; logic ov, un; int lat;
        int spurious;
        bus.op_a = 32'h3FC00000;
        bus.op_b = 32'h3FC00000;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.in_ready, bus.out_valid, bus.overflag, bus.underflag, bus.result} !== {4'b1000, 32'h0}) begin
            miscompares++;
            $display("FAIL abort_outputs: got rdy/vld/ov/un %b result %h expected 1000 00000000",
                     {bus.in_ready, bus.out_valid, bus.overflag, bus.underflag}, bus.result);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        spurious = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.out_valid || !bus.in_ready) spurious++;
            @(posedge clk); #1;
        end
        vectors++;
        if (spurious != 0) begin
            miscompares++;
            $display("FAIL abort_no_result: got %0d busy cycles expected 0", spurious);
        end
        do_op(32'h40000000, 32'h40400000, res, ov, un, lat);
        vectors++;
        if ({lat, ov, un, res} !== {LAT, 2'b00, 32'h40C00000}) begin
            miscompares++;
            $display("FAIL abort_recover: got lat %0d %b%b_%h expected lat %0d 00_40C00000", lat, ov, un, res, LAT);
        end
        handshake();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.op_a      = 32'h0;
        bus.op_b      = 32'h0;
        bus.out_ready = 1'b0;
        test_reset();
        test_arith();
        test_range();
        test_zero_path();
        test_backpressure();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
